// File: rtl/fpga_template_pkg.sv
// Shared types and constants for the debug frame checker.
// Frame layout: "DBG: " header, payload 0x00..0x0F, CR LF trailer.
package fpga_template_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_TRAIL   = 2'd3
    } dbg_chk_state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_HDR     = 3'd1,
        ERR_PAYLOAD = 3'd2,
        ERR_TRAIL   = 3'd3,
        ERR_TIMEOUT = 3'd4
    } dbg_chk_err_t;

    localparam logic [7:0] HDR_B0 = 8'h44;
    localparam logic [7:0] HDR_B1 = 8'h42;
    localparam logic [7:0] HDR_B2 = 8'h47;
    localparam logic [7:0] HDR_B3 = 8'h3A;
    localparam logic [7:0] HDR_B4 = 8'h20;
    localparam logic [7:0] TRL_B0 = 8'h0D;
    localparam logic [7:0] TRL_B1 = 8'h0A;

    localparam int DBG_HDR_LEN     = 5;
    localparam int DBG_PAYLOAD_LEN = 16;
    localparam int DBG_FRAME_LEN   = 23;

    localparam logic [4:0] HDR_LAST = 5'(DBG_HDR_LEN - 1);
    localparam logic [4:0] PAY_LAST = 5'(DBG_PAYLOAD_LEN - 1);
    localparam logic [4:0] PAY_BASE = 5'(DBG_HDR_LEN);
    localparam logic [4:0] TRL_BASE = 5'(DBG_HDR_LEN + DBG_PAYLOAD_LEN);

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = HDR_B0;
            3'd1:    b = HDR_B1;
            3'd2:    b = HDR_B2;
            3'd3:    b = HDR_B3;
            3'd4:    b = HDR_B4;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] trl_byte(input logic idx);
        return idx ? TRL_B1 : TRL_B0;
    endfunction

endpackage

// File: rtl/debug_frame_checker_sat_counter8.sv
// 8-bit event counter that sticks at 0xFF instead of wrapping.
module sat_counter8 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [7:0] cnt_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = 8'h00;
        else if (inc_i && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= 8'h00;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/debug_frame_checker.sv
// Checks 23-byte "DBG: " frames from a UART byte stream, with inter-byte timeout.
// Define DBG_CHK_CAPTURE_EN to capture the offending byte/position on abort.
module debug_frame_checker
    import fpga_template_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code,
    output logic [7:0] frame_count,
    output logic [7:0] err_count,
    output logic       busy,
    output logic [1:0] state_mon,
    output logic [7:0] err_byte,
    output logic [4:0] err_index
);

    logic [1:0] rst_sync_q;
    logic       rst_n;

    // Async assert, two-flop synchronised release.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            rst_sync_q <= 2'b00;
        else
            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    dbg_chk_state_t state_q, state_d;
    dbg_chk_err_t   code_q, code_d;
    logic [4:0]     idx_q, idx_d;
    logic [15:0]    tmo_q, tmo_d;
    logic           ok_q, ok_d;
    logic           err_q, err_d;
    logic           busy_q;
    logic [7:0]     exp_byte;
    logic           mis_abort;
    logic           tmo_abort;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        code_d    = code_q;
        tmo_d     = 16'd0;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        mis_abort = 1'b0;
        tmo_abort = 1'b0;
        exp_byte  = HDR_B0;

        if (state_q != ST_IDLE && !rx_valid)
            tmo_d = tmo_q + 16'd1;

        unique case (state_q)
            ST_HDR:     exp_byte = hdr_byte(idx_q[2:0]);
            ST_PAYLOAD: exp_byte = {3'b000, idx_q};
            ST_TRAIL:   exp_byte = trl_byte(idx_q[0]);
            default:    exp_byte = HDR_B0;
        endcase

        if (rx_valid) begin
            if (rx_data == exp_byte) begin
                idx_d = idx_q + 5'd1;
                unique case (state_q)
                    ST_IDLE: begin
                        state_d = ST_HDR;
                        idx_d   = 5'd1;
                    end
                    ST_HDR: begin
                        if (idx_q == HDR_LAST) begin
                            state_d = ST_PAYLOAD;
                            idx_d   = 5'd0;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (idx_q == PAY_LAST) begin
                            state_d = ST_TRAIL;
                            idx_d   = 5'd0;
                        end
                    end
                    default: begin
                        if (idx_q[0]) begin
                            state_d = ST_IDLE;
                            idx_d   = 5'd0;
                            ok_d    = 1'b1;
                        end
                    end
                endcase
            end else if (state_q != ST_IDLE) begin
                mis_abort = 1'b1;
                err_d     = 1'b1;
                unique case (state_q)
                    ST_HDR:     code_d = ERR_HDR;
                    ST_PAYLOAD: code_d = ERR_PAYLOAD;
                    default:    code_d = ERR_TRAIL;
                endcase
                // A stray 'D' may be the start of the next frame.
                if (rx_data == HDR_B0) begin
                    state_d = ST_HDR;
                    idx_d   = 5'd1;
                end else begin
                    state_d = ST_IDLE;
                    idx_d   = 5'd0;
                end
            end
        end else if (state_q != ST_IDLE && tmo_d == TIMEOUT_CYCLES) begin
            tmo_abort = 1'b1;
            err_d     = 1'b1;
            code_d    = ERR_TIMEOUT;
            state_d   = ST_IDLE;
            idx_d     = 5'd0;
            tmo_d     = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= ERR_NONE;
            idx_q   <= 5'd0;
            tmo_q   <= 16'd0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    sat_counter8 u_frame_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (1'b0),
        .inc_i  (ok_d),
        .cnt_o  (frame_count)
    );

    sat_counter8 u_err_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (1'b0),
        .inc_i  (mis_abort | tmo_abort),
        .cnt_o  (err_count)
    );

`ifdef DBG_CHK_CAPTURE_EN
    logic [7:0] eb_q;
    logic [4:0] ei_q;
    logic [4:0] pos;

    always_comb begin
        pos = idx_q;
        unique case (state_q)
            ST_PAYLOAD: pos = idx_q + PAY_BASE;
            ST_TRAIL:   pos = idx_q + TRL_BASE;
            default:    pos = idx_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eb_q <= 8'h00;
            ei_q <= 5'd0;
        end else if (mis_abort) begin
            eb_q <= rx_data;
            ei_q <= pos;
        end else if (tmo_abort) begin
            eb_q <= 8'h00;
            ei_q <= 5'd0;
        end
    end

    assign err_byte  = eb_q;
    assign err_index = ei_q;
`else
    assign err_byte  = 8'h00;
    assign err_index = 5'd0;
`endif

    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;
    assign busy      = busy_q;
    assign state_mon = state_q;

endmodule

// File: tb/tb_debug_frame_checker.sv
// Directed self-checking bench for debug_frame_checker (TIMEOUT_CYCLES=100).
module tb_debug_frame_checker;

    logic       clk = 1'b0;
    logic       resetb;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;
    logic [7:0] frame_count;
    logic [7:0] err_count;
    logic       busy;
    logic [1:0] state_mon;
    logic [7:0] err_byte;
    logic [4:0] err_index;

    int tests = 0;
    int fails = 0;

    debug_frame_checker #(.TIMEOUT_CYCLES(16'd100)) dut (
        .clk         (clk),
        .resetb      (resetb),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .frame_count (frame_count),
        .err_count   (err_count),
        .busy        (busy),
        .state_mon   (state_mon),
        .err_byte    (err_byte),
        .err_index   (err_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fb(input int i);
        logic [7:0] b;
        case (i)
            0:       b = 8'h44;
            1:       b = 8'h42;
            2:       b = 8'h47;
            3:       b = 8'h3A;
            4:       b = 8'h20;
            21:      b = 8'h0D;
            22:      b = 8'h0A;
            default: b = 8'(i - 5);
        endcase
        return b;
    endfunction

    // Called at a negedge; the byte is sampled on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_range(input int first, input int last);
        for (int i = first; i <= last; i++)
            send_byte(fb(i));
    endtask

    initial begin
        resetb   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (4) @(negedge clk);

        check("rst_ok", frame_ok, 0);
        check("rst_err", frame_err, 0);
        check("rst_code", err_code, 0);
        check("rst_fcnt", frame_count, 0);
        check("rst_ecnt", err_count, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state_mon, 0);
        check("rst_ebyte", err_byte, 0);
        check("rst_eidx", err_index, 0);

        resetb = 1'b1;
        repeat (3) @(negedge clk);

        send_byte(8'h55);
        check("idle_junk_err", frame_err, 0);
        check("idle_junk_ecnt", err_count, 0);
        check("idle_junk_state", state_mon, 0);

        // Good frame at 16-cycle spacing
        for (int i = 0; i < 22; i++) begin
            send_byte(fb(i));
            if (i == 4) check("hdr_done_state", state_mon, 2);
            if (i == 20) check("pay_done_state", state_mon, 3);
            if (i == 21) check("cr_no_ok", frame_ok, 0);
            repeat (15) @(negedge clk);
        end
        send_byte(fb(22));
        check("good_ok", frame_ok, 1);
        check("good_fcnt", frame_count, 1);
        check("good_ecnt", err_count, 0);
        check("good_state", state_mon, 0);
        @(negedge clk);
        check("good_ok_pulse", frame_ok, 0);
        check("good_busy", busy, 0);

        // Header mismatch
        send_byte(8'h44);
        send_byte(8'h42);
        send_byte(8'h58);
        check("hdr_err", frame_err, 1);
        check("hdr_code", err_code, 1);
        check("hdr_state", state_mon, 0);
        check("hdr_ecnt", err_count, 1);
`ifdef DBG_CHK_CAPTURE_EN
        check("hdr_ebyte", err_byte, 8'h58);
        check("hdr_eidx", err_index, 2);
`else
        check("hdr_ebyte", err_byte, 0);
        check("hdr_eidx", err_index, 0);
`endif
        @(negedge clk);
        check("hdr_err_pulse", frame_err, 0);

        // Payload 0x07 replaced by 'D', then resync into a good frame
        send_range(0, 11);
        send_byte(8'h44);
        check("pay_err", frame_err, 1);
        check("pay_code", err_code, 2);
        check("pay_state", state_mon, 1);
        check("pay_busy", busy, 1);
        check("pay_ecnt", err_count, 2);
`ifdef DBG_CHK_CAPTURE_EN
        check("pay_ebyte", err_byte, 8'h44);
        check("pay_eidx", err_index, 12);
`endif
        send_range(1, 22);
        check("resync_ok", frame_ok, 1);
        check("resync_fcnt", frame_count, 2);
        check("resync_code_held", err_code, 2);

        // Timeout: 100 idle cycles after last byte
        send_range(0, 7);
        repeat (99) @(negedge clk);
        check("tmo_99_err", frame_err, 0);
        check("tmo_99_state", state_mon, 2);
        @(negedge clk);
        check("tmo_err", frame_err, 1);
        check("tmo_code", err_code, 4);
        check("tmo_state", state_mon, 0);
        check("tmo_ecnt", err_count, 3);
`ifdef DBG_CHK_CAPTURE_EN
        check("tmo_ebyte", err_byte, 0);
        check("tmo_eidx", err_index, 0);
`endif

        // Byte arriving on the expiry cycle wins
        send_range(0, 7);
        repeat (99) @(negedge clk);
        send_byte(fb(8));
        check("tmo_race_err", frame_err, 0);
        check("tmo_race_state", state_mon, 2);
        check("tmo_race_ecnt", err_count, 3);
        send_range(9, 22);
        check("tmo_race_ok", frame_ok, 1);
        check("tmo_race_fcnt", frame_count, 3);

        // Trailer mismatch
        send_range(0, 21);
        send_byte(8'h0B);
        check("trl_err", frame_err, 1);
        check("trl_code", err_code, 3);
        check("trl_ecnt", err_count, 4);
`ifdef DBG_CHK_CAPTURE_EN
        check("trl_ebyte", err_byte, 8'h0B);
        check("trl_eidx", err_index, 22);
`endif

        // Asynchronous reset mid-payload
        send_range(0, 9);
        #2 resetb = 1'b0;
        #1;
        check("mid_rst_fcnt", frame_count, 0);
        check("mid_rst_ecnt", err_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_state", state_mon, 0);
        check("mid_rst_code", err_code, 0);
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        send_byte(8'h44);
        check("rel_first_edge_ignored", state_mon, 0);
        @(negedge clk);
        send_range(0, 21);
        check("rel_no_early_ok", frame_ok, 0);
        send_byte(fb(22));
        check("rel_ok", frame_ok, 1);
        check("rel_fcnt", frame_count, 1);
        check("rel_ecnt", err_count, 0);
        @(negedge clk);
        check("rel_ok_pulse", frame_ok, 0);

        // Saturation, back-to-back bytes
        for (int f = 0; f < 300; f++)
            send_range(0, 22);
        check("sat_fcnt", frame_count, 8'hFF);
        check("sat_fcnt_ecnt", err_count, 0);
        for (int f = 0; f < 300; f++) begin
            send_byte(8'h44);
            send_byte(8'h58);
        end
        check("sat_ecnt", err_count, 8'hFF);
        check("sat_fcnt_hold", frame_count, 8'hFF);
        check("sat_code", err_code, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
